// File: rtl/mem_readback_serializer.sv
// Sweeps a block-RAM read address over an inclusive (possibly wrapping) range and serializes
// each word LSB-first onto a valid/ready stream with a running XOR checksum. Option: READBACK_PREFETCH_EN.
module mem_readback_serializer #(
    parameter int WID_MEM   = 256,
    parameter int DEPTH_MEM = 256,
    parameter int AW        = 8,
    parameter int OUT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [AW-1:0]      first_addr,
    input  logic [AW-1:0]      last_addr,
    output logic [AW-1:0]      raddr,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic [OUT_W-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               done,
    output logic [OUT_W-1:0]   checksum
);

    localparam int BPW = WID_MEM / OUT_W;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BPW - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SHIFT, DONE} state_t;
    state_t state_reg, state_next;

    logic [AW-1:0]      last_reg;
    logic [AW-1:0]      cur_reg;
    logic [WID_MEM-1:0] shift_reg;
    logic [CW-1:0]      beat_reg;
    logic               accept, last_beat, last_word, reload;
    logic               pf_issue, pf_ready, pf_pending;
    logic [WID_MEM-1:0] hold_word;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(DEPTH_MEM - 1)) ? '0 : a + 1'b1;
    endfunction

    assign accept    = m_valid & m_ready;
    assign last_beat = (beat_reg == LAST_BEAT);
    assign last_word = (cur_reg == last_reg);
    assign m_data    = shift_reg[OUT_W-1:0];
    // Back-to-back continuation from already-fetched data of the next word
    assign reload    = (state_reg == SHIFT) && accept && last_beat && !last_word && pf_ready;

`ifdef READBACK_PREFETCH_EN
    logic [WID_MEM-1:0] hold_reg;
    logic               hold_valid_reg;
    logic [1:0]         pf_sr_reg;

    // Next word's read goes out as soon as beat 0 of the current word is taken
    assign pf_issue   = (state_reg == SHIFT) && accept && (beat_reg == '0) && !last_beat && !last_word;
    assign pf_ready   = hold_valid_reg | pf_sr_reg[1];
    assign pf_pending = pf_sr_reg[0];
    assign hold_word  = hold_valid_reg ? hold_reg : mem_dout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            pf_sr_reg      <= '0;
        end else begin
            pf_sr_reg <= {pf_sr_reg[0], pf_issue};
            if (reload || state_reg == WAIT) begin
                hold_valid_reg <= 1'b0;
            end else if (pf_sr_reg[1]) begin
                hold_reg       <= mem_dout;
                hold_valid_reg <= 1'b1;
            end
        end
    end
`else
    assign pf_issue   = 1'b0;
    assign pf_ready   = 1'b0;
    assign pf_pending = 1'b0;
    assign hold_word  = mem_dout;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  state_next = SHIFT;
            SHIFT: begin
                if (accept && last_beat) begin
                    if (last_word)       state_next = DONE;
                    else if (pf_ready)   state_next = SHIFT;
                    else if (pf_pending) state_next = WAIT;
                    else                 state_next = ISSUE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raddr     <= '0;
            last_reg  <= '0;
            cur_reg   <= '0;
            shift_reg <= '0;
            beat_reg  <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        raddr    <= first_addr;
                        last_reg <= last_addr;
                        checksum <= '0;
                        busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    shift_reg <= mem_dout;
                    cur_reg   <= raddr;
                    beat_reg  <= '0;
                    m_valid   <= 1'b1;
                    m_last    <= (BPW == 1) && (raddr == last_reg);
                end
                SHIFT: begin
                    if (accept) begin
                        checksum <= checksum ^ m_data;
                        if (pf_issue) raddr <= addr_inc(raddr);
                        if (!last_beat) begin
                            shift_reg <= shift_reg >> OUT_W;
                            beat_reg  <= beat_reg + 1'b1;
                            m_last    <= last_word && (beat_reg == CW'(BPW - 2));
                        end else if (last_word) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (pf_ready) begin
                            shift_reg <= hold_word;
                            cur_reg   <= addr_inc(cur_reg);
                            beat_reg  <= '0;
                            m_last    <= (BPW == 1) && (addr_inc(cur_reg) == last_reg);
                        end else begin
                            m_valid <= 1'b0;
                            // A pending prefetch has already moved raddr on
                            if (!pf_pending) raddr <= addr_inc(raddr);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
